full_adder: RTL and testbench

FULL_ADDER -- requirements
Module: full_adder

---
 rtl/full_adder_pkg.sv | 12 +
 rtl/full_adder_cell.sv | 23 ++
 rtl/full_adder.sv | 47 ++++
 tb/tb_full_adder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared constants and types for the registered 1-bit full adder.
// Integrators and benches use FA_LATENCY to align against out_valid.
package full_adder_pkg;

    localparam int FA_LATENCY = 1;

    typedef struct packed {
        logic sum;
        logic cout;
    } fa_result_t;

endpackage

// File: rtl/full_adder_cell.sv
// Purely combinational 1-bit full-adder cell; no state and no clock.
module full_adder_cell
    import full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    fa_result_t res;

    always_comb begin
        res      = '0;
        res.sum  = a ^ b ^ ci;
        res.cout = (a & b) | (a & ci) | (b & ci);
    end

    assign s  = res.sum;
    assign co = res.cout;

endmodule

// File: rtl/full_adder.sv
// Registered 1-bit full adder with optional bit-serial carry chaining.
// The cout register doubles as the stored carry, so the two can never diverge.
module full_adder
    import full_adder_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic in_valid,
    input  logic chain,
    output logic sum,
    output logic cout,
    output logic out_valid
);

    logic ci_eff;
    logic sum_next;
    logic cout_next;

    // In bit-serial mode the previous carry-out feeds this bit; cin is ignored.
    assign ci_eff = chain ? cout : cin;

    full_adder_cell u_cell (
        .a  (a),
        .b  (b),
        .ci (ci_eff),
        .s  (sum_next),
        .co (cout_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum       <= 1'b0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            sum       <= sum_next;
            cout      <= cout_next;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: arithmetic reference model plus directed and random stimulus.
module tb_full_adder;
    import full_adder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic cin = 1'b0;
    logic in_valid = 1'b0;
    logic chain = 1'b0;
    logic sum;
    logic cout;
    logic out_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic vld;
        logic s;
        logic c;
    } exp_t;

    exp_t exp_q[$];

    // Reference state: the visible registers after the next edge.
    logic m_sum = 1'b0;
    logic m_cout = 1'b0;
    logic m_vld = 1'b0;

    full_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .chain     (chain),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic v, input logic ch,
                        input logic ai, input logic bi, input logic ci);
        int total;
        int carry_in;
        @(negedge clk);
        rst_n = r; in_valid = v; chain = ch; a = ai; b = bi; cin = ci;
        if (!r) begin
            m_sum = 1'b0; m_cout = 1'b0; m_vld = 1'b0;
        end else if (v) begin
            carry_in = ch ? int'(m_cout) : int'(ci);
            total = int'(ai) + int'(bi) + carry_in;
            m_sum = (total % 2) != 0;
            m_cout = (total / 2) != 0;
            m_vld = 1'b1;
        end else begin
            m_vld = 1'b0;
        end
        exp_q.push_back('{vld: m_vld, s: m_sum, c: m_cout});
    endtask

    task automatic comb_check();
        logic s0;
        logic c0;
        @(posedge clk);
        #3;
        s0 = sum; c0 = cout;
        a = ~a; b = ~b; cin = ~cin; chain = ~chain; in_valid = ~in_valid;
        #1;
        checks++;
        if (sum !== s0 || cout !== c0) begin
            errors++;
            $display("FAIL comb_path sum/cout got %b%b expected %b%b", sum, cout, s0, c0);
        end
    endtask

    // Monitor: one expected entry per clocked cycle, checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (out_valid !== e.vld || sum !== e.s || cout !== e.c) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t got vld=%b sum=%b cout=%b expected vld=%b sum=%b cout=%b",
                             $time, out_valid, sum, cout, e.vld, e.s, e.c);
                end
            end
        end
    end

    initial begin
        logic [3:0] opa;
        logic [3:0] opb;
        int wait_cycles;

        // Reset state.
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Exhaustive truth table with external carry.
        for (int i = 0; i < 8; i++) begin
            opa = 4'(i);
            step(1, 1, 0, opa[2], opa[1], opa[0]);
        end

        // Reset wins over a simultaneous operation.
        step(0, 1, 0, 1, 1, 1);
        step(1, 0, 0, 1, 1, 1);

        // Hold: one result, then three idle cycles with toggling inputs.
        step(1, 1, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++)
            step(1, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

        // Inputs changing between edges must not reach the outputs.
        comb_check();
        comb_check();

        // Mid-chain reset clears the stored carry.
        step(1, 1, 0, 1, 1, 0);
        step(0, 0, 1, 1, 1, 1);
        step(1, 1, 1, 1, 0, 1);

        // Bit-serial 1011 + 0110, LSB first.
        opa = 4'b1011;
        opb = 4'b0110;
        for (int i = 0; i < 4; i++)
            step(1, 1, (i != 0), opa[i], opb[i], 1'b0);
        step(1, 0, 0, 0, 0, 0);

        // Random traffic with occasional resets and chaining.
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 15) != 0), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));
        step(1, 0, 0, 0, 0, 0);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10 * FA_LATENCY + 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #3;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
